slength_decoder: RTL and testbench

SLENGTH_DECODER -- requirements
Module: slength_decoder

---
 rtl/slength_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_slength_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slength_decoder.sv
// slength_decoder: serial decoder for DEFLATE fixed-Huffman length/EOB symbols.
// Receives the code MSB-first. Symbols 256..287 are valid, but 286 and 287
// are rejected as errors. The decoder then collects the RFC 1951 extra bits
// LSB-first and presents the resulting match length (or end-of-block) using a
// valid/ready handshake.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   clear_in          synchronous abort: drops partial symbol, clears error
//   bit_in            serial stream bit
//   bit_valid_in      bit_in is valid this cycle
//   bit_ready_out     decoder accepts a bit this cycle
//   match_length_out  decoded match length (3..258), 0 for end-of-block
//   eob_out           symbol was 256; qualified by length_valid_out
//   length_valid_out  result available
//   length_ready_in   downstream consumes the result
//   error_out         sticky error: invalid or non-length code seen
module slength_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_in,
  input  logic       bit_in,
  input  logic       bit_valid_in,
  output logic       bit_ready_out,
  output logic [8:0] match_length_out,
  output logic       eob_out,
  output logic       length_valid_out,
  input  logic       length_ready_in,
  output logic       error_out
);

  localparam logic [1:0] ST_CODE  = 2'd0;
  localparam logic [1:0] ST_EXTRA = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  logic [1:0] state_q;
  logic       started_q;    // low until the first edge after reset release
  logic [2:0] cnt_q;        // code bits consumed so far
  logic [6:0] shreg_q;      // code bits, first received at the MSB end
  logic [8:0] base_q;
  logic [2:0] ext_need_q;
  logic [2:0] ext_cnt_q;
  logic [4:0] ext_val_q;
  logic [8:0] len_q;
  logic       eob_q;

  logic       take;
  logic [6:0] v7;
  logic       sym_done;
  logic       sym_bad;
  logic [4:0] sym_off;      // symbol - 256
  logic [8:0] tbl_base;
  logic [2:0] tbl_extra;
  logic [4:0] ext_full;
  logic [8:0] ext_sum;

  assign bit_ready_out    = started_q && ((state_q == ST_CODE) || (state_q == ST_EXTRA));
  assign take             = bit_valid_in && bit_ready_out;
  assign length_valid_out = (state_q == ST_OUT);
  assign error_out        = (state_q == ST_ERR);
  assign match_length_out = len_q;
  assign eob_out          = eob_q;

  assign v7       = {shreg_q[5:0], bit_in};
  assign ext_full = ext_val_q | ({4'b0000, bit_in} << ext_cnt_q);
  assign ext_sum  = base_q + {4'b0000, ext_full};

  // Code classification on the 7th/8th consumed bit. In the 8th-bit branch
  // shreg_q still holds the 7-bit prefix 11000xx. Only its two low bits plus
  // bit_in select among symbols 280..287.
  always_comb begin
    sym_done = 1'b0;
    sym_bad  = 1'b0;
    sym_off  = '0;
    if (state_q == ST_CODE && take) begin
      if (cnt_q == 3'd6) begin
        if (v7 <= 7'h17) begin
          sym_done = 1'b1;
          sym_off  = v7[4:0];
        end else if (v7[6:2] != 5'b11000) begin
          sym_bad = 1'b1;
        end
      end else if (cnt_q == 3'd7) begin
        if (shreg_q[6:2] != 5'b11000 || shreg_q[1:0] == 2'b11) begin
          sym_bad = 1'b1;
        end else begin
          sym_done = 1'b1;
          sym_off  = 5'd24 + {2'b00, shreg_q[1:0], bit_in};
        end
      end
    end
  end

  // RFC 1951 length base / extra-bit table indexed by symbol - 256.
  always_comb begin
    tbl_base  = '0;
    tbl_extra = '0;
    case (sym_off)
      5'd1:  tbl_base = 9'd3;
      5'd2:  tbl_base = 9'd4;
      5'd3:  tbl_base = 9'd5;
      5'd4:  tbl_base = 9'd6;
      5'd5:  tbl_base = 9'd7;
      5'd6:  tbl_base = 9'd8;
      5'd7:  tbl_base = 9'd9;
      5'd8:  tbl_base = 9'd10;
      5'd9:  begin tbl_base = 9'd11;  tbl_extra = 3'd1; end
      5'd10: begin tbl_base = 9'd13;  tbl_extra = 3'd1; end
      5'd11: begin tbl_base = 9'd15;  tbl_extra = 3'd1; end
      5'd12: begin tbl_base = 9'd17;  tbl_extra = 3'd1; end
      5'd13: begin tbl_base = 9'd19;  tbl_extra = 3'd2; end
      5'd14: begin tbl_base = 9'd23;  tbl_extra = 3'd2; end
      5'd15: begin tbl_base = 9'd27;  tbl_extra = 3'd2; end
      5'd16: begin tbl_base = 9'd31;  tbl_extra = 3'd2; end
      5'd17: begin tbl_base = 9'd35;  tbl_extra = 3'd3; end
      5'd18: begin tbl_base = 9'd43;  tbl_extra = 3'd3; end
      5'd19: begin tbl_base = 9'd51;  tbl_extra = 3'd3; end
      5'd20: begin tbl_base = 9'd59;  tbl_extra = 3'd3; end
      5'd21: begin tbl_base = 9'd67;  tbl_extra = 3'd4; end
      5'd22: begin tbl_base = 9'd83;  tbl_extra = 3'd4; end
      5'd23: begin tbl_base = 9'd99;  tbl_extra = 3'd4; end
      5'd24: begin tbl_base = 9'd115; tbl_extra = 3'd4; end
      5'd25: begin tbl_base = 9'd131; tbl_extra = 3'd5; end
      5'd26: begin tbl_base = 9'd163; tbl_extra = 3'd5; end
      5'd27: begin tbl_base = 9'd195; tbl_extra = 3'd5; end
      5'd28: begin tbl_base = 9'd227; tbl_extra = 3'd5; end
      5'd29: tbl_base = 9'd258;
      default: begin
        tbl_base  = '0;
        tbl_extra = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CODE;
      started_q  <= 1'b0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      base_q     <= '0;
      ext_need_q <= '0;
      ext_cnt_q  <= '0;
      ext_val_q  <= '0;
      len_q      <= '0;
      eob_q      <= 1'b0;
    end else begin
      started_q <= 1'b1;
      if (clear_in) begin
        state_q    <= ST_CODE;
        cnt_q      <= '0;
        shreg_q    <= '0;
        base_q     <= '0;
        ext_need_q <= '0;
        ext_cnt_q  <= '0;
        ext_val_q  <= '0;
        len_q      <= '0;
        eob_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_CODE: begin
            if (take) begin
              if (sym_bad) begin
                state_q <= ST_ERR;
              end else if (sym_done) begin
                cnt_q   <= '0;
                shreg_q <= '0;
                if (sym_off == 5'd0) begin
                  eob_q   <= 1'b1;
                  len_q   <= '0;
                  state_q <= ST_OUT;
                end else if (tbl_extra == 3'd0) begin
                  eob_q   <= 1'b0;
                  len_q   <= tbl_base;
                  state_q <= ST_OUT;
                end else begin
                  base_q     <= tbl_base;
                  ext_need_q <= tbl_extra;
                  ext_cnt_q  <= '0;
                  ext_val_q  <= '0;
                  state_q    <= ST_EXTRA;
                end
              end else begin
                cnt_q   <= cnt_q + 3'd1;
                shreg_q <= v7;
              end
            end
          end
          ST_EXTRA: begin
            if (take) begin
              if (ext_cnt_q == ext_need_q - 3'd1) begin
                len_q   <= ext_sum;
                eob_q   <= 1'b0;
                state_q <= ST_OUT;
              end else begin
                ext_cnt_q <= ext_cnt_q + 3'd1;
                ext_val_q <= ext_full;
              end
            end
          end
          ST_OUT: begin
            if (length_ready_in) begin
              state_q   <= ST_CODE;
              cnt_q     <= '0;
              shreg_q   <= '0;
              ext_cnt_q <= '0;
              ext_val_q <= '0;
            end
          end
          default: state_q <= ST_ERR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slength_decoder.sv
module tb_slength_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_in;
  logic       bit_in;
  logic       bit_valid_in;
  logic       bit_ready_out;
  logic [8:0] match_length_out;
  logic       eob_out;
  logic       length_valid_out;
  logic       length_ready_in;
  logic       error_out;

  typedef struct packed {
    logic       eob;
    logic [8:0] len;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   gap    = 0;

  slength_decoder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear_in         (clear_in),
    .bit_in           (bit_in),
    .bit_valid_in     (bit_valid_in),
    .bit_ready_out    (bit_ready_out),
    .match_length_out (match_length_out),
    .eob_out          (eob_out),
    .length_valid_out (length_valid_out),
    .length_ready_in  (length_ready_in),
    .error_out        (error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Tasks are entered and left 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    int t;
    t = 0;
    bit_valid_in = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    while (bit_ready_out !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) chk("ready_timeout", {31'd0, bit_ready_out}, 32'd1);
    bit_in       = b;
    bit_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bit_valid_in = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic push_res(input logic [8:0] len, input logic eob);
    res_t r;
    r.len = len;
    r.eob = eob;
    sb.push_back(r);
  endtask

  task automatic expect_result(input string tag);
    res_t e;
    chk({tag, "_valid"}, {31'd0, length_valid_out}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_len"}, {23'd0, match_length_out}, {23'd0, e.len});
      chk({tag, "_eob"}, {31'd0, eob_out}, {31'd0, e.eob});
    end
    length_ready_in = 1'b1;
    @(posedge clk);
    #1;
    length_ready_in = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, length_valid_out}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, bit_ready_out}, 32'd1);
  endtask

  task automatic pulse_clear();
    clear_in = 1'b1;
    @(posedge clk);
    #1;
    clear_in = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    clear_in        = 1'b0;
    bit_in          = 1'b0;
    bit_valid_in    = 1'b0;
    length_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bit_ready_out}, 32'd0);
    chk("rst_valid", {31'd0, length_valid_out}, 32'd0);
    chk("rst_eob", {31'd0, eob_out}, 32'd0);
    chk("rst_err", {31'd0, error_out}, 32'd0);
    chk("rst_len", {23'd0, match_length_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, bit_ready_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", {31'd0, bit_ready_out}, 32'd1);

    // symbol 257
    push_res(9'd3, 1'b0);
    send_bits(16'b0000001, 7);
    expect_result("s257");

    // symbol 265 + extra 1
    push_res(9'd12, 1'b0);
    send_bits(16'b0001001, 7);
    send_bits(16'd1, 1);
    expect_result("s265");

    // symbol 284 + extra 0,1,1,1,1 (LSB first -> 30)
    push_res(9'd257, 1'b0);
    send_bits(16'b11000100, 8);
    send_bits(16'b01111, 5);
    expect_result("s284");

    // symbol 285
    push_res(9'd258, 1'b0);
    send_bits(16'b11000101, 8);
    expect_result("s285");

    // end of block
    push_res(9'd0, 1'b1);
    send_bits(16'b0000000, 7);
    expect_result("eob");

    // symbol 264, last zero-extra symbol before the extra-bit range
    push_res(9'd10, 1'b0);
    send_bits(16'b0001000, 7);
    expect_result("s264");

    // symbol 281 + extra all ones -> 131+31
    push_res(9'd162, 1'b0);
    send_bits(16'b11000001, 8);
    send_bits(16'b11111, 5);
    expect_result("s281");

    // symbol 273 with idle gaps, extra 1,0,1 LSB first -> 5
    gap = 2;
    push_res(9'd40, 1'b0);
    send_bits(16'b0010001, 7);
    send_bits(16'b101, 3);
    gap = 0;
    expect_result("s273_gaps");

    // invalid 7-bit code
    send_bits(16'b0011000, 7);
    chk("bad7_err", {31'd0, error_out}, 32'd1);
    chk("bad7_ready", {31'd0, bit_ready_out}, 32'd0);
    chk("bad7_valid", {31'd0, length_valid_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bad7_sticky", {31'd0, error_out}, 32'd1);
    pulse_clear();
    chk("clr1_err", {31'd0, error_out}, 32'd0);
    chk("clr1_ready", {31'd0, bit_ready_out}, 32'd1);

    // symbol 286
    send_bits(16'b11000110, 8);
    chk("s286_err", {31'd0, error_out}, 32'd1);
    chk("s286_valid", {31'd0, length_valid_out}, 32'd0);
    pulse_clear();
    chk("clr2_err", {31'd0, error_out}, 32'd0);
    chk("clr2_ready", {31'd0, bit_ready_out}, 32'd1);

    // clear mid-symbol, with a bit offered on the same cycle
    send_bits(16'b110, 3);
    bit_in       = 1'b1;
    bit_valid_in = 1'b1;
    pulse_clear();
    bit_valid_in = 1'b0;
    push_res(9'd3, 1'b0);
    send_bits(16'b0000001, 7);
    expect_result("after_clear");

    // backpressure
    push_res(9'd4, 1'b0);
    send_bits(16'b0000010, 7);
    bit_in       = 1'b1;
    bit_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, length_valid_out}, 32'd1);
      chk("bp_len", {23'd0, match_length_out}, 32'd4);
      chk("bp_eob", {31'd0, eob_out}, 32'd0);
      chk("bp_ready", {31'd0, bit_ready_out}, 32'd0);
      @(posedge clk);
      #1;
    end
    bit_valid_in = 1'b0;
    expect_result("bp_out");
    push_res(9'd10, 1'b0);
    send_bits(16'b0001000, 7);
    expect_result("bp_next");

    // reset after 4 code bits
    send_bits(16'b0000, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, length_valid_out}, 32'd0);
    chk("mid_rst_ready", {31'd0, bit_ready_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_pulse", {31'd0, length_valid_out}, 32'd0);
    end
    push_res(9'd4, 1'b0);
    send_bits(16'b0000010, 7);
    expect_result("s258_after_rst");

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
